// File: rtl/seq_mul_rs_param.sv
// Serial right-shift multiplier: one iteration per clock, unsigned shift-add or radix-2 Booth.
// Start/done handshake; the product register holds its value until the next completion.
module seq_mul_rs_param #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_reg;
    logic [WIDTH:0]     acc_reg;
    logic [WIDTH:0]     m_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               qm1_reg;
    logic [CW-1:0]      count_reg;
    logic               mode_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [2*WIDTH-1:0] product_reg;

    logic [WIDTH:0]     sum_next;
    logic [WIDTH:0]     acc_next;
    logic [WIDTH-1:0]   q_next;

    // The extra accumulator bit is the unsigned carry or the Booth sign guard,
    // so neither mode can overflow, even for M = -2^(WIDTH-1).
    always_comb begin
        sum_next = acc_reg;
        if (mode_reg) begin
            case ({q_reg[0], qm1_reg})
                2'b10:   sum_next = acc_reg - m_reg;
                2'b01:   sum_next = acc_reg + m_reg;
                default: sum_next = acc_reg;
            endcase
        end else if (q_reg[0]) begin
            sum_next = acc_reg + m_reg;
        end
        acc_next = {mode_reg & sum_next[WIDTH], sum_next[WIDTH:1]};
        q_next   = {sum_next[0], q_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            m_reg       <= '0;
            q_reg       <= '0;
            qm1_reg     <= 1'b0;
            count_reg   <= '0;
            mode_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        m_reg     <= {is_signed & a[WIDTH-1], a};
                        q_reg     <= b;
                        acc_reg   <= '0;
                        qm1_reg   <= 1'b0;
                        count_reg <= CW'(WIDTH);
                        mode_reg  <= is_signed;
                        busy_reg  <= 1'b1;
                        state_reg <= CALC;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    acc_reg   <= acc_next;
                    q_reg     <= q_next;
                    qm1_reg   <= q_reg[0];
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        product_reg <= {acc_next[WIDTH-1:0], q_next};
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;
endmodule

// File: tb/tb_seq_mul_rs_param.sv
// Bench for seq_mul_rs_param: 6-bit and 8-bit instances checked every cycle against an
// arithmetic model, plus directed vectors with hand-computed products.
module tb_seq_mul_rs_param;
    logic        clk = 1'b0;
    logic        rst6 = 1'b0, rst8 = 1'b0;
    logic        st6 = 1'b0, st8 = 1'b0, sg6 = 1'b0, sg8 = 1'b0;
    logic [5:0]  a6 = '0, b6 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy6, done6, busy8, done8;
    logic [11:0] prod6;
    logic [15:0] prod8;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_mul_rs_param #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst6), .start(st6), .is_signed(sg6), .a(a6), .b(b6),
        .busy(busy6), .done(done6), .product(prod6)
    );

    seq_mul_rs_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(st8), .is_signed(sg8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    function automatic logic [11:0] ref6(input logic [5:0] x, input logic [5:0] y, input logic s);
        logic [11:0] r;
        if (s) r = $signed({{6{x[5]}}, x}) * $signed({{6{y[5]}}, y});
        else   r = {6'b0, x} * {6'b0, y};
        return r;
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [15:0] r;
        if (s) r = $signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y});
        else   r = {8'b0, x} * {8'b0, y};
        return r;
    endfunction

    // Model: an accepted request makes the unit busy for WIDTH edges, then the exact
    // product appears with a one-cycle done; requests while busy are dropped.
    int          m6_left, m8_left;
    logic        m6_done, m8_done;
    logic [11:0] m6_prod, m6_pend;
    logic [15:0] m8_prod, m8_pend;

    always @(posedge clk or negedge rst6) begin
        if (!rst6) begin
            m6_left <= 0; m6_done <= 1'b0; m6_prod <= '0; m6_pend <= '0;
        end else begin
            m6_done <= 1'b0;
            if (m6_left > 0) begin
                m6_left <= m6_left - 1;
                if (m6_left == 1) begin
                    m6_prod <= m6_pend;
                    m6_done <= 1'b1;
                end
            end else if (st6) begin
                m6_left <= 6;
                m6_pend <= ref6(a6, b6, sg6);
            end
        end
    end

    always @(posedge clk or negedge rst8) begin
        if (!rst8) begin
            m8_left <= 0; m8_done <= 1'b0; m8_prod <= '0; m8_pend <= '0;
        end else begin
            m8_done <= 1'b0;
            if (m8_left > 0) begin
                m8_left <= m8_left - 1;
                if (m8_left == 1) begin
                    m8_prod <= m8_pend;
                    m8_done <= 1'b1;
                end
            end else if (st8) begin
                m8_left <= 8;
                m8_pend <= ref8(a8, b8, sg8);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            total++;
            if (busy6 !== (m6_left > 0) || done6 !== m6_done || prod6 !== m6_prod) begin
                bad++;
                $display("FAIL model6 t=%0t got busy=%b done=%b product=%h want busy=%b done=%b product=%h",
                         $time, busy6, done6, prod6, (m6_left > 0), m6_done, m6_prod);
            end
            total++;
            if (busy8 !== (m8_left > 0) || done8 !== m8_done || prod8 !== m8_prod) begin
                bad++;
                $display("FAIL model8 t=%0t got busy=%b done=%b product=%h want busy=%b done=%b product=%h",
                         $time, busy8, done8, prod8, (m8_left > 0), m8_done, m8_prod);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic wait_done6(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done6 !== 1'b1 && k < 40);
    endtask

    task automatic run(input int w, input logic [7:0] x, input logic [7:0] y, input logic s,
                       input logic [15:0] exp, input string name);
        int k;
        logic got;
        @(negedge clk);
        if (w == 6) begin a6 = x[5:0]; b6 = y[5:0]; sg6 = s; st6 = 1'b1; end
        else        begin a8 = x;      b8 = y;      sg8 = s; st8 = 1'b1; end
        @(negedge clk);
        st6 = 1'b0; st8 = 1'b0;
        a6 = '0; b6 = '0; a8 = '0; b8 = '0;
        k = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            got = (w == 6) ? done6 : done8;
        end
        check({name, "_latency"}, 16'(k), 16'(w));
        check(name, (w == 6) ? {4'b0, prod6} : prod8, exp);
        $display("txn %s w=%0d a=%h b=%h signed=%b product=%h cycles=%0d",
                 name, w, x, y, s, (w == 6) ? {4'b0, prod6} : prod8, k);
    endtask

    initial begin
        int k, n;
        repeat (2) @(negedge clk);
        check("reset_busy", {15'b0, busy6}, 16'h0);
        check("reset_done", {15'b0, done6}, 16'h0);
        check("reset_product", {4'b0, prod6}, 16'h0);
        rst6 = 1'b1; rst8 = 1'b1;

        run(6, 8'd21, 8'd3, 1'b0, 16'h003F, "u21x3");
        repeat (3) @(negedge clk);
        check("hold_product", {4'b0, prod6}, 16'h003F);

        run(6, 8'h2B, 8'h03, 1'b1, 16'h0FC1, "s_m21x3");
        run(6, 8'h20, 8'h20, 1'b1, 16'h0400, "s_m32xm32");
        run(6, 8'h20, 8'h1F, 1'b1, 16'h0C20, "s_m32x31");
        run(6, 8'd63, 8'd63, 1'b0, 16'h0F81, "u63x63");
        run(6, 8'd0, 8'd45, 1'b0, 16'h0000, "u0x45");

        // Start held high through CALC with new operands: accepted again only in DONE.
        @(negedge clk);
        a6 = 6'd45; b6 = 6'd1; sg6 = 1'b0; st6 = 1'b1;
        @(negedge clk);
        a6 = 6'd2; b6 = 6'd5;
        wait_done6(k);
        check("b2b_first_latency", 16'(k), 16'd6);
        check("b2b_first", {4'b0, prod6}, 16'd45);
        $display("txn b2b_first a=2d b=01 product=%h", prod6);
        @(negedge clk);
        st6 = 1'b0;
        wait_done6(k);
        check("b2b_spacing", 16'(k + 1), 16'd7);
        check("b2b_second", {4'b0, prod6}, 16'd10);
        $display("txn b2b_second a=02 b=05 product=%h", prod6);

        // Start pulse during CALC is ignored.
        @(negedge clk);
        a6 = 6'd10; b6 = 6'd10; st6 = 1'b1;
        @(negedge clk);
        st6 = 1'b0;
        repeat (2) @(negedge clk);
        a6 = 6'd3; b6 = 6'd3; st6 = 1'b1;
        @(negedge clk);
        st6 = 1'b0;
        wait_done6(k);
        check("calc_start_ignored", {4'b0, prod6}, 16'd100);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (done6) n++;
        end
        check("no_extra_done", 16'(n), 16'd0);
        $display("txn ignore_start a=0a b=0a product=%h extra_done=%0d", prod6, n);

        // Asynchronous reset during iteration 3 of 5*5.
        @(negedge clk);
        a6 = 6'd5; b6 = 6'd5; st6 = 1'b1;
        @(negedge clk);
        st6 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst6 = 1'b0;
        #1;
        check("async_rst_busy", {15'b0, busy6}, 16'h0);
        check("async_rst_done", {15'b0, done6}, 16'h0);
        check("async_rst_product", {4'b0, prod6}, 16'h0);
        $display("txn async_reset product=%h busy=%b", prod6, busy6);
        repeat (2) @(negedge clk);
        rst6 = 1'b1;
        run(6, 8'd5, 8'd5, 1'b0, 16'd25, "u5x5_after_rst");

        run(8, 8'hFF, 8'hFF, 1'b0, 16'hFE01, "w8_u255x255");
        run(8, 8'h80, 8'h7F, 1'b1, 16'hC080, "w8_s_m128x127");
        run(8, 8'h80, 8'h80, 1'b1, 16'h4000, "w8_s_m128xm128");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
